// File: rtl/uart_rx_fifo_if.sv
// Receive-side word stream: head-of-FIFO data with its error flags on a valid/ready handshake.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  perr;
    logic                  ferr;
    logic                  valid;
    logic                  ready;

    modport master (output data, perr, ferr, valid, input ready);
    modport slave  (input data, perr, ferr, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, run-time baud divisor, per-word error
// flags and a receive FIFO feeding a valid/ready stream.
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 rx_sig,
    uart_rx_fifo_if.master       rx_if,
    output logic                 overrun,
    output logic                 brk,
    output logic                 busy
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_WIDTH + 2;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = 1;
    localparam logic [BW-1:0]        BIT_ONE  = 1;
    localparam logic [BW-1:0]        BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [AW-1:0]        PTR_ONE  = 1;
    localparam logic [AW:0]          CNT_ONE  = 1;
    localparam logic [AW:0]          CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic                 ODD      = (PARITY == 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] PAR     = 3'd3;
    localparam logic [2:0] STOP1   = 3'd4;
    localparam logic [2:0] STOP2   = 3'd5;
    localparam logic [2:0] BRKWAIT = 3'd6;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             hist_q;
    logic                   rxf;

    logic [2:0]            state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_r_q, div_r_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  par_q, par_d;
    logic                  push_q, push_d;
    logic                  brk_q, brk_d;
    logic [WW-1:0]         word_q, word_d;
    logic                  busy_q;
    logic                  expire;

    // Majority of the newest synchronised sample and the two before it rejects 1-clock glitches.
    assign rxf = (sync_q[SYNC_STAGES-1] & hist_q[0]) |
                 (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                 (hist_q[0] & hist_q[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_sig};
            hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
        end
    end

    assign expire = (cnt_q == '0);

    always_comb begin
        // NOTE: every _d gets a default here, so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = expire ? cnt_q : cnt_q - DIV_ONE;
        div_r_d = div_r_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        par_d   = par_q;
        push_d  = 1'b0;
        brk_d   = 1'b0;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                if (!rxf) begin
                    state_d = START;
                    div_r_d = div;
                    cnt_d   = (div >> 1) - DIV_ONE;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    par_d   = 1'b0;
                end
            end
            START: begin
                if (expire) begin
                    if (rxf) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = div_r_q - DIV_ONE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_d = {rxf, shreg_q[DATA_WIDTH-1:1]};
                    cnt_d   = div_r_q - DIV_ONE;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP1;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            PAR: begin
                if (expire) begin
                    par_d   = rxf;
                    perr_d  = ((^shreg_q) ^ rxf) != ODD;
                    cnt_d   = div_r_q - DIV_ONE;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (expire && STOP_BITS == 2) begin
                    ferr_d  = ~rxf;
                    cnt_d   = div_r_q - DIV_ONE;
                    state_d = STOP2;
                end
            end
            STOP2: ;
            BRKWAIT: begin
                if (rxf) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Final stop sample: the word is queued for the FIFO on the following cycle.
        if (expire && (state_q == STOP2 || (state_q == STOP1 && STOP_BITS != 2))) begin
            push_d  = 1'b1;
            word_d  = {ferr_q | ~rxf, perr_q, shreg_q};
            brk_d   = ~rxf && (shreg_q == '0) && !par_q;
            state_d = rxf ? IDLE : BRKWAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_r_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            par_q   <= 1'b0;
            push_q  <= 1'b0;
            brk_q   <= 1'b0;
            word_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_r_q <= div_r_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            par_q   <= par_d;
            push_q  <= push_d;
            brk_q   <= brk_d;
            word_q  <= word_d;
            busy_q  <= (state_q != IDLE);
        end
    end

    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overrun_q;
    logic          full, valid, pop, do_push;
    logic [WW-1:0] head;

    assign full    = (count_q == CNT_FULL);
    assign valid   = (count_q != '0);
    assign pop     = valid & rx_if.ready;
    assign do_push = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !pop)      count_q <= count_q + CNT_ONE;
            else if (!do_push && pop) count_q <= count_q - CNT_ONE;
            overrun_q <= push_q & full & ~pop;
        end
    end

    // NOTE: storage is left unreset; the outputs are gated by valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= word_q;
    end

    assign head        = mem_q[rd_ptr_q];
    assign rx_if.valid = valid;
    assign rx_if.data  = valid ? head[DATA_WIDTH-1:0] : '0;
    assign rx_if.perr  = valid & head[DATA_WIDTH];
    assign rx_if.ferr  = valid & head[DATA_WIDTH+1];
    assign overrun     = overrun_q;
    assign brk         = brk_q;
    assign busy        = busy_q;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Next-generation UART receiver with a configurable frame format, a run-time baud divisor, per-word error flags and a built-in receive FIFO. It converts one asynchronous serial line into words on a valid/ready stream. It replaces the fixed-format receiver wherever parity, two stop bits, run-time baud selection or burst buffering are needed. It feeds the same valid/ready consumers as the fixed-format receiver.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- DIV_WIDTH, 16: width of the baud divisor input.
- FIFO_DEPTH, 4: receive FIFO entries, power of two, ≥2.
- SYNC_STAGES, 2: input synchroniser flops, ≥2.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- div  in  DIV_WIDTH  clocks per bit, ≥8; captured at start detection.
- rx_sig  in  1  asynchronous serial input, idle high.
- data  out  DATA_WIDTH  head-of-FIFO data.
- perr  out  1  parity error flag of the head word.
- ferr  out  1  framing error flag of the head word.
- valid  out  1  FIFO non-empty.
- ready  in  1  consumer accepts the head word when valid && ready.
- overrun  out  1  1-cycle pulse: a completed word was dropped because the FIFO was full.
- brk  out  1  1-cycle pulse: break detected.
- busy  out  1  FSM not in IDLE.

## Operation
- Input path: rx_sig passes through SYNC_STAGES flops, then a 3-tap majority of the last three synchronised samples, evaluated every clock, gives rxf. All stages reset to 1.
- Bit timer: down-counter cnt, DIV_WIDTH bits. "Expiry" means cnt==0; otherwise cnt decrements.
- The FSM has the following states:
  - IDLE: rxf==0 → START. Latch div into div_r and load cnt = div/2 − 1, using floor division.
  - START: at expiry, rxf==1 is a false start → IDLE. Otherwise load cnt = div_r − 1 → DATA with bit index 0.
  - DATA: at each expiry, shift rxf in LSB-first and reload cnt = div_r − 1. After bit DATA_WIDTH−1, go to PARITY if PARITY≠0, else STOP1.
  - PARITY: at expiry, sample p. perr = (XOR of data ^ p) != (PARITY==1 ? 1 : 0); that is, odd parity needs total ones odd. → STOP1.
  - STOP1: at expiry, sample. A 0 sets ferr. If STOP_BITS==2 → STOP2, else finish.
  - STOP2: same as STOP1, then finish. ferr is the OR of both stop samples being 0.
  - Finish: push {ferr, perr, data} in the cycle after the final stop sample. If the final stop sample was 1 → IDLE. If it was 0 → BRKWAIT.
  - BRKWAIT: wait for rxf==1 → IDLE. Nothing is pushed meanwhile.
- Break detection: the data bits, and the parity bit if present, were all 0 and the final stop sample was 0. brk pulses once, in the push cycle. The word 0 with ferr=1 is still pushed.
- A div change mid-frame has no effect until the next start.
- FIFO behaviour:
  - Push on frame finish; pop on valid && ready.
  - Full and push without pop: drop the word and pulse overrun; FIFO contents are unchanged.
  - Full with simultaneous push and pop: both take effect and there is no overrun.
  - Empty with push: valid rises the next cycle, with no same-cycle bypass.
  - Order is preserved. Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is $clog2(FIFO_DEPTH)+1.
- Reset values:
  - All outputs are 0: data, perr, ferr, valid, overrun, brk, busy.
  - FSM is in IDLE and the FIFO is empty.
  - An in-progress frame is discarded.
  - Reset asserted mid-frame takes effect on the next clk edge, with no partial push.

## Timing
- Start detect lags the line falling edge by SYNC_STAGES + 2 clocks, covering the synchroniser plus the majority filter settling.
- Data bit k is sampled floor(div/2) + (k+1)·div clocks after start detect.
- Push occurs 1 clock after the final stop sample. valid is high 1 clock after the push.
- With FIFO_DEPTH words buffered and ready held low, the word that completes next is lost with exactly one overrun pulse.
- A back-to-back start bit arriving half a bit after the final stop sample is caught. The FSM is in IDLE by then.
- busy rises the cycle after start detect and falls the cycle after the return to IDLE.

## Test plan
- DATA_WIDTH=8, PARITY=2, STOP_BITS=1, div=16: send 0xA5 with parity bit 0 → one word data=0xA5, perr=0, ferr=0; valid holds until ready.
- Same configuration, send 0x3C with parity bit 1 → data=0x3C, perr=1. Send 0x81 with stop bit 0 and line then high → data=0x81, ferr=1, no brk.
- Idle line, 1-clock low glitch, then a 3-clock low pulse → no word, busy stays 0 or returns to 0 after START, no push.
- FIFO_DEPTH=4, ready=0, send 0x01..0x05 → 4 words held, one overrun pulse on 0x05. Then ready=1 → 0x01, 0x02, 0x03, 0x04 in order, then valid=0.
- Hold rx_sig low for 20 bit times, then high → exactly one word 0x00 with ferr=1, one brk pulse, no further words. Next frame 0x55 is received correctly.
- Runtime div change 16→10 between frames, with a mid-frame change ignored. rst pulsed mid-frame → no word; the next frame is received cleanly.
